// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control unit:
// FSM states, opcodes, ALU operations and datapath mux selects.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        AOP_ADD,
        AOP_SUB,
        AOP_FUNCT
    } alu_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_J = 3'd3;
    localparam logic [2:0] IMM_U = 3'd4;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2  = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    function automatic logic branch_taken(
        input logic [2:0] f3,
        input logic       z,
        input logic       lt,
        input logic       ltu
    );
        logic t;
        case (f3)
            3'b000:  t = z;
            3'b001:  t = !z;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = ltu;
            3'b111:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU decoder: operation class plus funct fields
// to the shared ALU's operation code.
import mc_ctrl_pkg::*;

module mc_alu_decoder #(
    parameter int ALU_CTRL_W = 4
) (
    input  alu_op_e               alu_op_i,
    input  logic [2:0]            funct3_i,
    input  logic                  funct7b5_i,
    input  logic                  op5_i,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (alu_op_i)
            AOP_SUB: code = ALU_SUB;
            AOP_FUNCT: begin
                case (funct3_i)
                    // op5 separates R-type from immediates: ADDI never subtracts
                    3'b000: code = (op5_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b001: code = ALU_SLL;
                    3'b010: code = ALU_SLT;
                    3'b011: code = ALU_SLTU;
                    3'b100: code = ALU_XOR;
                    3'b101: code = funct7b5_i ? ALU_SRA : ALU_SRL;
                    3'b110: code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alu_ctrl_o = ALU_CTRL_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM sequencing fetch/decode/execute/
// memory/writeback over one shared memory port with a ready handshake.
import mc_ctrl_pkg::*;

module multicycle_control #(
    parameter int ALU_CTRL_W = 4,
    parameter int EXT_BRANCH = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr_i,
    input  logic                  zero_i,
    input  logic                  lt_i,
    input  logic                  ltu_i,
    input  logic                  mem_ready_i,
    output logic                  mem_req_o,
    output logic                  mem_write_o,
    output logic                  adr_src_o,
    output logic                  ir_write_o,
    output logic                  pc_write_o,
    output logic                  reg_write_o,
    output logic [1:0]            result_src_o,
    output logic [1:0]            alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic [2:0]            imm_src_o,
    output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
    output logic                  retire_o,
    output logic                  illegal_o
);

    state_e     state_q, state_d;
    alu_op_e    alu_op;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       br_legal;
    logic       unused_instr;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign unused_instr = ^{instr_i[31], instr_i[29:15], instr_i[11:7]};

    assign br_legal = (EXT_BRANCH != 0) ? (funct3[2:1] != 2'b01)
                                        : (funct3[2:1] == 2'b00);

    mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
        .alu_op_i   (alu_op),
        .funct3_i   (funct3),
        .funct7b5_i (instr_i[30]),
        .op5_i      (opcode[5]),
        .alu_ctrl_o (alu_ctrl_o)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        mem_req_o    = 1'b0;
        mem_write_o  = 1'b0;
        adr_src_o    = 1'b0;
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        reg_write_o  = 1'b0;
        result_src_o = RES_ALUOUT;
        alu_src_a_o  = SRCA_PC;
        alu_src_b_o  = SRCB_RS2;
        imm_src_o    = IMM_I;
        alu_op       = AOP_ADD;
        retire_o     = 1'b0;
        illegal_o    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_req_o    = 1'b1;
                alu_src_b_o  = SRCB_FOUR;
                result_src_o = RES_ALU;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_IMM;
                imm_src_o   = IMM_B;
                // Jumps precompute their target into ALUOut here
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I, OP_LUI:      state_d = S_EXEC_I;
                    OP_BRANCH: state_d = br_legal ? S_BRANCH : S_TRAP;
                    OP_JAL: begin
                        imm_src_o = IMM_J;
                        state_d   = S_JAL;
                    end
                    OP_JALR: begin
                        alu_src_a_o = SRCA_RS1;
                        imm_src_o   = IMM_I;
                        state_d     = S_JALR;
                    end
                    default: state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = SRCA_RS1;
                alu_src_b_o = SRCB_IMM;
                imm_src_o   = opcode[5] ? IMM_S : IMM_I;
                state_d     = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req_o = 1'b1;
                adr_src_o = 1'b1;
                if (mem_ready_i) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_o = RES_MEM;
                reg_write_o  = 1'b1;
                retire_o     = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req_o   = 1'b1;
                adr_src_o   = 1'b1;
                mem_write_o = 1'b1;
                if (mem_ready_i) begin
                    retire_o = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a_o = SRCA_RS1;
                alu_op      = AOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_b_o = SRCB_IMM;
                if (opcode == OP_LUI) begin
                    alu_src_a_o = SRCA_ZERO;
                    imm_src_o   = IMM_U;
                end else begin
                    alu_src_a_o = SRCA_RS1;
                    alu_op      = AOP_FUNCT;
                end
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o = SRCA_RS1;
                alu_op      = AOP_SUB;
                pc_write_o  = branch_taken(funct3, zero_i, lt_i, ltu_i);
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_JAL, S_JALR: begin
                alu_src_a_o = SRCA_OLDPC;
                alu_src_b_o = SRCB_FOUR;
                pc_write_o  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_TRAP: illegal_o = 1'b1;
            default: state_d = S_FETCH;
        endcase
        // Reset must not let the FETCH state leak a write mid-assertion
        if (!rst_n) begin
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            reg_write_o = 1'b0;
            mem_write_o = 1'b0;
            retire_o    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instructions push
// expected retire records; a negedge monitor pops and compares them.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero, lt, ltu, mem_ready;

    logic       mem_req, mem_write, adr_src, ir_write, pc_write;
    logic       reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b;
    logic [2:0] imm_src;
    logic [3:0] alu_ctrl;

    logic       b_mem_req, b_mem_write, b_adr_src, b_ir_write;
    logic       b_pc_write, b_reg_write, b_retire, b_illegal;
    logic [1:0] b_result_src, b_alu_src_a, b_alu_src_b;
    logic [2:0] b_imm_src;
    logic [3:0] b_alu_ctrl;

    typedef struct {
        int lat;
        int pcw;
        int rw;
        int rs;
        int alu_prev;
        int alu_ret;
        int nreq;
        int nadr;
        int nwr;
    } exp_t;

    exp_t sb[$];
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    multicycle_control #(.ALU_CTRL_W(4), .EXT_BRANCH(1)) dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req),
        .mem_write_o(mem_write), .adr_src_o(adr_src),
        .ir_write_o(ir_write), .pc_write_o(pc_write),
        .reg_write_o(reg_write), .result_src_o(result_src),
        .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .imm_src_o(imm_src), .alu_ctrl_o(alu_ctrl),
        .retire_o(retire), .illegal_o(illegal)
    );

    multicycle_control #(.ALU_CTRL_W(4), .EXT_BRANCH(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .instr_i(instr),
        .zero_i(zero), .lt_i(lt), .ltu_i(ltu),
        .mem_ready_i(mem_ready), .mem_req_o(b_mem_req),
        .mem_write_o(b_mem_write), .adr_src_o(b_adr_src),
        .ir_write_o(b_ir_write), .pc_write_o(b_pc_write),
        .reg_write_o(b_reg_write), .result_src_o(b_result_src),
        .alu_src_a_o(b_alu_src_a), .alu_src_b_o(b_alu_src_b),
        .imm_src_o(b_imm_src), .alu_ctrl_o(b_alu_ctrl),
        .retire_o(b_retire), .illegal_o(b_illegal)
    );

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(
        input int lat, input int pcw, input int rw, input int rs,
        input int ap, input int ar, input int nreq, input int nadr,
        input int nwr
    );
        exp_t e;
        e.lat = lat; e.pcw = pcw; e.rw = rw; e.rs = rs;
        e.alu_prev = ap; e.alu_ret = ar;
        e.nreq = nreq; e.nadr = nadr; e.nwr = nwr;
        return e;
    endfunction

    // One instruction: cycles wlo..whi have mem_ready low
    task automatic run(
        input logic [31:0] ins, input logic z, input logic l,
        input logic lu, input int lat, input int wlo, input int whi,
        input exp_t e
    );
        instr = ins; zero = z; lt = l; ltu = lu;
        sb.push_back(e);
        for (int k = 1; k <= lat; k++) begin
            mem_ready = !(k >= wlo && k <= whi);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1;
    endtask

    int cnt, nreq, nadr, nwr, prev_alu;

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0; nreq = 0; nadr = 0; nwr = 0; prev_alu = 0;
        end else begin
            cnt++;
            if (mem_req)   nreq++;
            if (adr_src)   nadr++;
            if (mem_write) nwr++;
            if (retire) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("latency", cnt, e.lat);
                    chk("pc_write@retire", int'(pc_write), e.pcw);
                    chk("reg_write@retire", int'(reg_write), e.rw);
                    chk("result_src@retire", int'(result_src), e.rs);
                    chk("alu_ctrl@exec", prev_alu, e.alu_prev);
                    chk("alu_ctrl@retire", int'(alu_ctrl), e.alu_ret);
                    chk("mem_req_cycles", nreq, e.nreq);
                    chk("adr_src_cycles", nadr, e.nadr);
                    chk("mem_write_cycles", nwr, e.nwr);
                end
                cnt = 0; nreq = 0; nadr = 0; nwr = 0;
            end
            prev_alu = int'(alu_ctrl);
        end
    end

    initial begin
        rst_n = 1'b0; instr = 32'h0; mem_ready = 1'b1;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_mem_req", int'(mem_req), 1);
        chk("rst_ir_write", int'(ir_write), 0);
        chk("rst_pc_write", int'(pc_write), 0);
        chk("rst_reg_write", int'(reg_write), 0);
        chk("rst_mem_write", int'(mem_write), 0);
        chk("rst_retire", int'(retire), 0);
        chk("rst_illegal", int'(illegal), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run(32'h002081B3, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 0, 0, 1, 0, 0));
        run(32'h402081B3, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 1, 0, 1, 0, 0));
        run(32'h4020D1B3, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 8, 0, 1, 0, 0));
        run(32'h4030D193, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 8, 0, 1, 0, 0));
        run(32'h0030D193, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 7, 0, 1, 0, 0));
        run(32'hC0008193, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 0, 0, 1, 0, 0));
        run(32'h123452B7, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 0, 0, 1, 0, 0));
        run(32'h0000A283, 0, 0, 0, 7, 4, 5, mk(7, 0, 1, 1, 0, 0, 4, 3, 0));
        run(32'h0020A223, 0, 0, 0, 5, 1, 1, mk(5, 0, 0, 0, 0, 0, 3, 1, 1));
        run(32'h00208463, 1, 0, 0, 3, 0, -1, mk(3, 1, 0, 0, 0, 1, 1, 0, 0));
        run(32'h00208463, 0, 0, 0, 3, 0, -1, mk(3, 0, 0, 0, 0, 1, 1, 0, 0));
        run(32'h00209463, 0, 0, 0, 3, 0, -1, mk(3, 1, 0, 0, 0, 1, 1, 0, 0));
        run(32'h0020D463, 0, 0, 0, 3, 0, -1, mk(3, 1, 0, 0, 0, 1, 1, 0, 0));
        run(32'h0020E463, 0, 0, 1, 3, 0, -1, mk(3, 1, 0, 0, 0, 1, 1, 0, 0));
        run(32'h0020F463, 0, 0, 1, 3, 0, -1, mk(3, 0, 0, 0, 0, 1, 1, 0, 0));
        run(32'h010000EF, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 0, 0, 1, 0, 0));
        run(32'h000100E7, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 0, 0, 1, 0, 0));
        run(32'h0020C463, 0, 1, 0, 3, 0, -1, mk(3, 1, 0, 0, 0, 1, 1, 0, 0));
        chk("ext0_blt_illegal", int'(b_illegal), 1);
        chk("ext0_trap_mem_req", int'(b_mem_req), 0);
        chk("ext1_blt_legal", int'(illegal), 0);

        // Store stalled in MEMWRITE, then reset mid-access
        instr = 32'h0020A223; zero = 1'b0; lt = 1'b0; ltu = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk("memwrite_mem_write", int'(mem_write), 1);
        chk("memwrite_adr_src", int'(adr_src), 1);
        #2 rst_n = 1'b0;
        #1 mem_ready = 1'b1;
        #1;
        chk("rstmid_mem_write", int'(mem_write), 0);
        chk("rstmid_adr_src", int'(adr_src), 0);
        chk("rstmid_mem_req", int'(mem_req), 1);
        chk("rstmid_ir_write", int'(ir_write), 0);
        chk("rstmid_illegal_clr", int'(b_illegal), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        instr = 32'h00000000;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
        end
        chk("trap_illegal", int'(illegal), 1);
        chk("trap_mem_req", int'(mem_req), 0);
        chk("trap_reg_write", int'(reg_write), 0);
        @(posedge clk); #1;
        chk("trap_sticky", int'(illegal), 1);
        rst_n = 1'b0;
        #1 chk("trap_rst_clr", int'(illegal), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        run(32'h402081B3, 0, 0, 0, 4, 0, -1, mk(4, 0, 1, 0, 1, 0, 1, 0, 0));
        @(posedge clk); @(posedge clk); #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
